// File: rtl/atb_pkg.sv
// Shared types and constants for the ATB trace transmitter.
package atb_pkg;

  localparam int unsigned ATB_DATA_W = 32;
  localparam int unsigned ATB_ID_W   = 7;

  localparam logic [ATB_ID_W-1:0] ATB_ID_NULL    = 7'h00;
  localparam logic [ATB_ID_W-1:0] ATB_ID_RSVD_LO = 7'h70;
  localparam logic [ATB_ID_W-1:0] ATB_ID_RSVD_HI = 7'h7F;

  typedef struct packed {
    logic [ATB_DATA_W-1:0] data;
    logic [1:0]            bytes;
  } atb_beat_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    ACK
  } flush_state_t;

  function automatic logic atb_id_reserved(input logic [ATB_ID_W-1:0] id);
    return (id == ATB_ID_NULL) || ((id >= ATB_ID_RSVD_LO) && (id <= ATB_ID_RSVD_HI));
  endfunction

endpackage

// File: rtl/atb_tx_fifo.sv
// Clock-enabled synchronous FIFO of ATB beats; pointers wrap modulo DEPTH.
module atb_tx_fifo
  import atb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     wr_i,
  input  atb_beat_t                wr_data_i,
  input  logic                     rd_i,
  output atb_beat_t                rd_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  atb_beat_t         mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_wr, do_rd;

  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign rd_data_o = mem_q[rptr_q];
  assign do_wr     = wr_i && (cnt_q != CW'(DEPTH));
  assign do_rd     = rd_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_wr) wptr_d = wptr_q + 1'b1;
    if (do_rd) rptr_d = rptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (en_i) begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i && do_wr) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/atb_tx_source.sv
// ATB trace transmitter: FIFO, registered output stage, flush FSM, sync pulse, wakeup.
// Optional stall counter port enabled by `define ATB_TX_STALL_CNT_EN.
module atb_tx_source
  import atb_pkg::*;
#(
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ATB_ID_W-1:0]  ATID_VAL = 7'h10
) (
  input  logic                  atclk,
  input  logic                  atresetn,
  input  logic                  atclken,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [ATB_DATA_W-1:0] src_data,
  input  logic [1:0]            src_bytes,
  output logic                  src_sync,
  output logic [ATB_DATA_W-1:0] atdata,
  output logic [1:0]            atbytes,
  output logic [ATB_ID_W-1:0]   atid,
  output logic                  atvalid,
  input  logic                  atready,
  input  logic                  afvalid,
  output logic                  afready,
  input  logic                  syncreq,
  output logic                  atwakeup
`ifdef ATB_TX_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (atb_id_reserved(ATID_VAL)) begin : g_bad_atid
    $error("atb_tx_source: ATID_VAL is a reserved trace ID");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("atb_tx_source: DEPTH must be a power of two >= 2");
  end

  atb_beat_t     head, beat_q, beat_d, wr_beat;
  logic          vld_q, vld_d;
  logic          fifo_empty, fifo_wr, load;
  logic [CW-1:0] fifo_cnt, occ;
  flush_state_t  state_q, state_d;
  logic          sync_prev_q, src_sync_q;

  // Occupancy includes the output stage, so "full" means DEPTH words in flight.
  assign occ       = fifo_cnt + CW'(vld_q);
  assign src_ready = (occ != CW'(DEPTH)) && (state_q == RUN);
  assign fifo_wr   = src_valid && src_ready;
  assign load      = !vld_q || atready;
  assign wr_beat   = '{data: src_data, bytes: src_bytes};

  atb_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (atclk),
    .rst_ni    (atresetn),
    .en_i      (atclken),
    .wr_i      (fifo_wr),
    .wr_data_i (wr_beat),
    .rd_i      (load),
    .rd_data_o (head),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  always_comb begin
    beat_d = beat_q;
    vld_d  = vld_q;
    if (load) begin
      vld_d = !fifo_empty;
      if (!fifo_empty) beat_d = head;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (afvalid) state_d = DRAIN;
      DRAIN:   if (fifo_empty && !vld_q) state_d = ACK;
      ACK:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      vld_q       <= 1'b0;
      beat_q      <= '0;
      state_q     <= RUN;
      sync_prev_q <= 1'b0;
      src_sync_q  <= 1'b0;
    end else if (atclken) begin
      vld_q       <= vld_d;
      beat_q      <= beat_d;
      state_q     <= state_d;
      sync_prev_q <= syncreq;
      src_sync_q  <= syncreq && !sync_prev_q;
    end
  end

  assign atvalid  = vld_q;
  assign atdata   = beat_q.data;
  assign atbytes  = beat_q.bytes;
  assign atid     = ATID_VAL;
  assign afready  = (state_q == ACK);
  assign src_sync = src_sync_q;
  assign atwakeup = vld_q || !fifo_empty || src_valid || (state_q != RUN);

`ifdef ATB_TX_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      stall_q <= '0;
    end else if (atclken && vld_q && !atready && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
